// File: rtl/subinst_rr_scheduler_if.sv
// Request/grant bundle between the round-robin scheduler and its sibling requesters.
// master = scheduler side (drives grants), slave = requester side.
interface subinst_rr_scheduler_if #(
  parameter int N_REQ = 5
);
  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rel;
  logic             res_busy;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_id;
  logic             timeout;
  logic [IW-1:0]    ptr;

  modport master (
    input  req, rel, res_busy,
    output gnt, gnt_valid, gnt_id, timeout, ptr
  );

  modport slave (
    output req, rel, res_busy,
    input  gnt, gnt_valid, gnt_id, timeout, ptr
  );
endinterface

// File: rtl/subinst_rr_scheduler.sv
// Round-robin owner of one shared resource among N_REQ sibling requesters, with hold timer.
// Latency: grant one cycle after req seen in IDLE; release one cycle after rel/withdraw/expiry.
// Backpressure: res_busy blocks new grants only; a held grant runs to release or timeout.
module subinst_rr_scheduler #(
  parameter int N_REQ    = 5,
  parameter int MAX_HOLD = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  subinst_rr_scheduler_if.master bus
);
  localparam int HW  = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam int IW  = $clog2(N_REQ);
  localparam int IW1 = IW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q;
  logic             timeout_q, timeout_d;

  logic             pick_vld;
  logic [IW-1:0]    pick_id;
  logic [IW1-1:0]   sum;

  // Scan downward so the candidate closest to ptr is the one left standing.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    sum      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + IW1'(k);
      if (sum >= IW1'(N_REQ)) begin
        sum = sum - IW1'(N_REQ);
      end
      if (bus.req[sum[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_id  = sum[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!bus.res_busy && pick_vld) begin
          state_d          = OWN;
          id_d             = pick_id;
          hold_d           = '0;
          gnt_d            = '0;
          gnt_d[pick_id]   = 1'b1;
        end
      end

      OWN: begin
        // Timeout is raised one edge early so it is visible, registered, in the final owned cycle.
        if (bus.rel[id_q] || !bus.req[id_q] || (hold_q == HW'(MAX_HOLD - 1))) begin
          state_d = GAP;
          gnt_d   = '0;
          id_d    = '0;
          hold_d  = '0;
          ptr_d   = (id_q == IW'(N_REQ - 1)) ? '0 : id_q + IW'(1);
        end else begin
          hold_d    = hold_q + HW'(1);
          timeout_d = (hold_q == HW'(MAX_HOLD - 2));
        end
      end

      GAP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        id_d    = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= |gnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = id_q;
  assign bus.timeout   = timeout_q;
  assign bus.ptr       = ptr_q;

endmodule

// File: tb/tb_subinst_rr_scheduler.sv
// Randomized and directed checks of subinst_rr_scheduler against a cycle-level ownership model.
module tb_subinst_rr_scheduler;
  localparam int N  = 5;
  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  subinst_rr_scheduler_if #(.N_REQ(N)) bus ();

  subinst_rr_scheduler #(.N_REQ(N), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: who owns, how many cycles they have owned, whether a turnaround is pending.
  int m_owner, m_held, m_ptr;
  bit m_gap, m_to;
  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_gap   = 0;
    m_to    = 0;
  endfunction

  function automatic void model_step();
    m_to = 0;
    if (m_owner >= 0) begin
      if (bus.rel[m_owner] || !bus.req[m_owner] || m_held == MH) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_held++;
        m_to = (m_held == MH);
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (!bus.res_busy && bus.req != 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && bus.req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          m_held  = 1;
        end
      end
    end
  endfunction

  task automatic check_outputs(input string pfx);
    chk({pfx, "_gnt"},   bus.gnt,       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk({pfx, "_valid"}, bus.gnt_valid, (m_owner >= 0) ? 32'd1 : 32'd0);
    chk({pfx, "_id"},    bus.gnt_id,    (m_owner >= 0) ? m_owner : 0);
    chk({pfx, "_to"},    bus.timeout,   m_to);
    chk({pfx, "_ptr"},   bus.ptr,       m_ptr);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  // Called at a negedge; checks outputs drop before any clock edge, releases before next posedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(input string tag);
    int budget;
    budget = 20;
    while (m_owner < 0 && budget > 0) begin
      cyc();
      budget--;
    end
    chk({tag, "_wait"}, (m_owner >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  int rot_exp [6] = '{0, 1, 2, 3, 4, 0};
  int hi, to_at;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.rel      = '0;
    bus.res_busy = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset and idle
    do_reset();
    repeat (10) cyc();

    // Rotation from ptr 0 with all requesting
    bus.req = 5'b11111;
    for (int k = 0; k < 6; k++) begin
      wait_grant("rot");
      chk("rot_order", bus.gnt_id, rot_exp[k]);
      bus.rel = 5'd1 << rot_exp[k];
      cyc();
      bus.rel = '0;
    end
    bus.req = '0;
    repeat (3) cyc();

    // Single requester, held three cycles
    bus.req = 5'b00100;
    wait_grant("single");
    cyc();
    cyc();
    bus.rel = 5'b00100;
    cyc();
    bus.rel = '0;
    bus.req = '0;
    chk("single_drop", bus.gnt, 0);
    chk("single_ptr", bus.ptr, 3);
    repeat (3) cyc();

    // Hold timer expiry
    bus.req = 5'b00010;
    wait_grant("to");
    hi    = 0;
    to_at = 0;
    for (int c = 1; c <= 20 && bus.gnt[1]; c++) begin
      hi = c;
      if (bus.timeout) to_at = c;
      cyc();
    end
    chk("to_len", hi, MH);
    chk("to_pulse_at", to_at, MH);
    chk("to_ptr", bus.ptr, 2);
    cyc();
    chk("to_idle_gap", bus.gnt, 0);
    cyc();
    chk("to_regrant", bus.gnt, 5'b00010);
    bus.req = '0;
    repeat (3) cyc();

    // Busy blocks new grants; release coinciding with the expiry decision wins
    @(negedge clk);
    model_step();
    check_outputs("sync");
    do_reset();
    bus.res_busy = 1'b1;
    bus.req      = 5'b01001;
    repeat (5) cyc();
    chk("busy_nogrant", bus.gnt, 0);
    bus.res_busy = 1'b0;
    cyc();
    chk("busy_grant", bus.gnt, 5'b00001);
    repeat (MH - 2) cyc();
    bus.rel = 5'b00001;
    cyc();
    bus.rel = '0;
    chk("coll_to", bus.timeout, 0);
    chk("coll_drop", bus.gnt, 0);
    bus.req = '0;
    repeat (3) cyc();

    // Asynchronous reset during ownership
    bus.req = 5'b01000;
    wait_grant("arst");
    cyc();
    chk("arst_pre", bus.gnt, 5'b01000);
    do_reset();
    chk("arst_gnt", bus.gnt, 0);
    cyc();
    chk("arst_regrant", bus.gnt, 5'b01000);
    bus.req = '0;
    repeat (3) cyc();

    // Random traffic
    for (int t = 0; t < 2500; t++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) bus.req[i] = ~bus.req[i];
      end
      bus.rel      = ($urandom_range(3) == 0) ? N'($urandom) : '0;
      bus.res_busy = ($urandom_range(3) == 0);
      if ($urandom_range(299) == 0) do_reset();
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
